// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared encodings and helpers for the data-memory access unit
package dmem_pkg;

    localparam logic [2:0] F3_B  = 3'd0;
    localparam logic [2:0] F3_H  = 3'd1;
    localparam logic [2:0] F3_W  = 3'd2;
    localparam logic [2:0] F3_BU = 3'd4;
    localparam logic [2:0] F3_HU = 3'd5;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACC0 = 2'd1,
        ST_ACC1 = 2'd2,
        ST_RESP = 2'd3
    } state_t;

    function automatic logic [3:0] size_mask(input logic [1:0] size);
        case (size)
            2'd0:    return 4'b0001;
            2'd1:    return 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic f3_legal(input logic we, input logic [2:0] f3);
        if (we)
            return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
        return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
               (f3 == F3_BU) || (f3 == F3_HU);
    endfunction

    // An access needs a second SRAM word when its bytes run past lane 3.
    function automatic logic is_split(input logic [2:0] f3, input logic [1:0] off);
        return ((f3[1:0] == 2'd2) && (off != 2'd0)) ||
               ((f3[1:0] == 2'd1) && (off == 2'd3));
    endfunction

endpackage

// File: rtl/dmem_align.sv
// rtl/dmem_align.sv - combinational lane steering for stores and merge/extend for loads
module dmem_align
    import dmem_pkg::*;
(
    input  logic [2:0]  i_funct3,
    input  logic [1:0]  i_off,
    input  logic        i_acc1,
    input  logic [31:0] i_wdata,
    input  logic [31:0] i_first,
    input  logic [31:0] i_second,
    output logic [3:0]  o_be,
    output logic [31:0] o_di,
    output logic [31:0] o_rdata
);

    logic [7:0]  w_mask8;
    logic [63:0] w_di64;
    logic [63:0] w_merged64;
    logic [31:0] w_merged;

    // The upper half of each 64-bit shift is exactly what spills into the next word.
    assign w_mask8    = {4'b0000, size_mask(i_funct3[1:0])} << i_off;
    assign w_di64     = {32'h0, i_wdata} << {i_off, 3'b000};
    assign w_merged64 = {i_second, i_first} >> {i_off, 3'b000};
    assign w_merged   = w_merged64[31:0];

    assign o_be = i_acc1 ? w_mask8[7:4] : w_mask8[3:0];
    assign o_di = i_acc1 ? w_di64[63:32] : w_di64[31:0];

    always_comb begin
        o_rdata = w_merged;
        case (i_funct3)
            F3_B:    o_rdata = {{24{w_merged[7]}}, w_merged[7:0]};
            F3_H:    o_rdata = {{16{w_merged[15]}}, w_merged[15:0]};
            F3_BU:   o_rdata = {24'h0, w_merged[7:0]};
            F3_HU:   o_rdata = {16'h0, w_merged[15:0]};
            default: o_rdata = w_merged;
        endcase
    end

endmodule

// File: rtl/dmem_access_unit.sv
// rtl/dmem_access_unit.sv - RV32 load/store front-end driving a single-port data SRAM
module dmem_access_unit
    import dmem_pkg::*;
#(
    parameter int AWIDTH = 12,
    parameter int SIZE   = 4096
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              REQ_VALID,
    output logic              REQ_READY,
    input  logic              REQ_WE,
    input  logic [2:0]        REQ_FUNCT3,
    input  logic [31:0]       REQ_ADDR,
    input  logic [31:0]       REQ_WDATA,
    output logic              RSP_VALID,
    output logic [31:0]       RSP_RDATA,
    output logic              RSP_ERR,
    output logic              MEM_CSN,
    output logic              MEM_WEN,
    output logic [3:0]        MEM_BE,
    output logic [AWIDTH-1:0] MEM_ADDR,
    output logic [31:0]       MEM_DI,
    input  logic [31:0]       MEM_DOUT
);

    localparam logic [AWIDTH-1:0] LAST_WORD = AWIDTH'(SIZE - 1);

    state_t            r_state;
    state_t            w_next;
    logic              r_we;
    logic [2:0]        r_f3;
    logic [1:0]        r_off;
    logic [AWIDTH-1:0] r_word;
    logic [31:0]       r_wdata;
    logic [31:0]       r_first;
    logic [31:0]       r_rdata;
    logic              r_err;

    logic              w_accept;
    logic              w_req_legal;
    logic              w_split;
    logic              w_acc1;
    logic [AWIDTH-1:0] w_word_next;
    logic [3:0]        w_be;
    logic [31:0]       w_di;
    logic [31:0]       w_load;
    logic              w_unused_addr;

    assign w_unused_addr = ^REQ_ADDR[31:AWIDTH+2];

    assign REQ_READY   = !RST && ((r_state == ST_IDLE) || (r_state == ST_RESP));
    assign w_accept    = REQ_VALID && REQ_READY;
    assign w_req_legal = f3_legal(REQ_WE, REQ_FUNCT3);
    assign w_split     = is_split(r_f3, r_off);
    assign w_acc1      = (r_state == ST_ACC1);
    assign w_word_next = (r_word == LAST_WORD) ? '0 : r_word + 1'b1;

    dmem_align u_align (
        .i_funct3 (r_f3),
        .i_off    (r_off),
        .i_acc1   (w_acc1),
        .i_wdata  (r_wdata),
        .i_first  (w_acc1 ? r_first : MEM_DOUT),
        .i_second (MEM_DOUT),
        .o_be     (w_be),
        .o_di     (w_di),
        .o_rdata  (w_load)
    );

    always_ff @(posedge CLK) begin
        if (RST) r_state <= ST_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE, ST_RESP: begin
                if (w_accept) w_next = w_req_legal ? ST_ACC0 : ST_RESP;
                else          w_next = ST_IDLE;
            end
            ST_ACC0: w_next = w_split ? ST_ACC1 : ST_RESP;
            ST_ACC1: w_next = ST_RESP;
            default: w_next = ST_IDLE;
        endcase
    end

    // RST masks the strobes immediately so a pending ACC1 write cannot reach its negedge.
    always_comb begin
        MEM_CSN   = 1'b1;
        MEM_WEN   = 1'b1;
        MEM_BE    = 4'b0000;
        MEM_ADDR  = '0;
        MEM_DI    = 32'h0;
        RSP_VALID = 1'b0;
        case (r_state)
            ST_ACC0, ST_ACC1: begin
                MEM_CSN  = RST;
                MEM_WEN  = RST || !r_we;
                MEM_ADDR = w_acc1 ? w_word_next : r_word;
                if (r_we) begin
                    MEM_BE = w_be;
                    MEM_DI = w_di;
                end
            end
            ST_RESP: RSP_VALID = !RST;
            default: ;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_we    <= 1'b0;
            r_f3    <= 3'd0;
            r_off   <= 2'd0;
            r_word  <= '0;
            r_wdata <= 32'h0;
            r_first <= 32'h0;
            r_rdata <= 32'h0;
            r_err   <= 1'b0;
        end else begin
            if (w_accept) begin
                r_we    <= REQ_WE;
                r_f3    <= REQ_FUNCT3;
                r_off   <= REQ_ADDR[1:0];
                r_word  <= REQ_ADDR[AWIDTH+1:2];
                r_wdata <= REQ_WDATA;
                r_rdata <= 32'h0;
                r_err   <= !w_req_legal;
            end
            if (r_state == ST_ACC0) r_first <= MEM_DOUT;
            if (!r_we && (((r_state == ST_ACC0) && !w_split) || w_acc1))
                r_rdata <= w_load;
        end
    end

    assign RSP_RDATA = r_rdata;
    assign RSP_ERR   = r_err;

endmodule

// File: tb/tb_dmem_access_unit.sv
// tb/tb_dmem_access_unit.sv - self-checking bench for dmem_access_unit
module tb_dmem_access_unit;

    localparam int AWIDTH = 12;
    localparam int SIZE   = 4096;

    logic              CLK = 1'b0;
    logic              RST;
    logic              REQ_VALID;
    logic              REQ_READY;
    logic              REQ_WE;
    logic [2:0]        REQ_FUNCT3;
    logic [31:0]       REQ_ADDR;
    logic [31:0]       REQ_WDATA;
    logic              RSP_VALID;
    logic [31:0]       RSP_RDATA;
    logic              RSP_ERR;
    logic              MEM_CSN;
    logic              MEM_WEN;
    logic [3:0]        MEM_BE;
    logic [AWIDTH-1:0] MEM_ADDR;
    logic [31:0]       MEM_DI;
    logic [31:0]       MEM_DOUT;

    always #5 CLK = ~CLK;

    dmem_access_unit #(.AWIDTH(AWIDTH), .SIZE(SIZE)) dut (
        .CLK(CLK), .RST(RST),
        .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY), .REQ_WE(REQ_WE),
        .REQ_FUNCT3(REQ_FUNCT3), .REQ_ADDR(REQ_ADDR), .REQ_WDATA(REQ_WDATA),
        .RSP_VALID(RSP_VALID), .RSP_RDATA(RSP_RDATA), .RSP_ERR(RSP_ERR),
        .MEM_CSN(MEM_CSN), .MEM_WEN(MEM_WEN), .MEM_BE(MEM_BE),
        .MEM_ADDR(MEM_ADDR), .MEM_DI(MEM_DI), .MEM_DOUT(MEM_DOUT)
    );

    logic [31:0] mem [SIZE];
    logic        preload_req = 1'b0;

    assign MEM_DOUT = mem[MEM_ADDR];

    always @(negedge CLK) begin
        if (preload_req) begin
            for (int i = 0; i < SIZE; i++) mem[i] = 32'h0;
            mem[0]      = 32'h8899AABB;
            mem[1]      = 32'h11223344;
            mem[SIZE-1] = 32'hDEADBEEF;
        end else if (!MEM_CSN && !MEM_WEN) begin
            for (int b = 0; b < 4; b++)
                if (MEM_BE[b]) mem[MEM_ADDR][8*b +: 8] = MEM_DI[8*b +: 8];
        end
    end

    int checks   = 0;
    int failures = 0;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endfunction

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    typedef struct packed {
        logic [AWIDTH-1:0] addr;
        logic              we;
        logic [3:0]        be;
        logic [31:0]       di;
    } acc_t;

    exp_t exp_q[$];
    acc_t acc_q[$];
    int   rsp_cyc_q[$];
    int   rsp_cnt = 0;
    int   cyc     = 0;
    int   acc_cyc = 0;

    always @(posedge CLK) cyc <= cyc + 1;

    always @(negedge CLK) begin
        exp_t e;
        if (!MEM_CSN) acc_q.push_back('{MEM_ADDR, !MEM_WEN, MEM_BE, MEM_DI});
        if (RSP_VALID) begin
            rsp_cnt++;
            rsp_cyc_q.push_back(cyc);
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_rsp: got rdata %h err %b with no request outstanding", RSP_RDATA, RSP_ERR);
            end else begin
                e = exp_q.pop_front();
                chk("rsp_rdata", RSP_RDATA, e.rdata);
                chk("rsp_err", 32'(RSP_ERR), 32'(e.err));
            end
        end
    end

    task automatic preload();
        preload_req = 1'b1;
        @(negedge CLK);
        @(negedge CLK);
        preload_req = 1'b0;
    endtask

    // Leaves REQ_VALID high at the negedge after the accept edge.
    task automatic send(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [31:0] rdata_exp, input logic err_exp);
        int n;
        n = 0;
        REQ_VALID  = 1'b1;
        REQ_WE     = we;
        REQ_FUNCT3 = f3;
        REQ_ADDR   = addr;
        REQ_WDATA  = wdata;
        while (!REQ_READY && n < 20) begin
            @(negedge CLK);
            n++;
        end
        if (!REQ_READY) begin
            checks++;
            failures++;
            $display("FAIL accept_timeout: REQ_READY got 0 expected 1 within 20 cycles");
        end else begin
            @(posedge CLK);
            acc_q.delete();
            exp_q.push_back('{rdata_exp, err_exp});
            @(negedge CLK);
            acc_cyc = cyc;
        end
    endtask

    task automatic wait_rsp(input int target);
        int n;
        n = 0;
        while (rsp_cnt < target && n < 20) begin
            @(negedge CLK);
            n++;
        end
        checks++;
        if (rsp_cnt < target) begin
            failures++;
            $display("FAIL rsp_timeout: got %0d responses expected %0d", rsp_cnt, target);
        end
    endtask

    typedef struct {
        logic              we;
        logic [2:0]        f3;
        logic [31:0]       addr;
        logic [31:0]       wdata;
        logic [31:0]       rdata;
        logic              err;
        int                nacc;
        int                lat;
        logic [AWIDTH-1:0] a0;
        logic [AWIDTH-1:0] a1;
    } vec_t;

    localparam int NV = 13;
    vec_t vecs[NV];

    initial begin
        int base;

        vecs[0]  = '{1'b0, 3'd2, 32'h0000_0000, 32'h0, 32'h8899AABB, 1'b0, 1, 1, 12'd0,    12'd0};
        vecs[1]  = '{1'b0, 3'd0, 32'h0000_0003, 32'h0, 32'hFFFFFF88, 1'b0, 1, 1, 12'd0,    12'd0};
        vecs[2]  = '{1'b0, 3'd4, 32'h0000_0003, 32'h0, 32'h00000088, 1'b0, 1, 1, 12'd0,    12'd0};
        vecs[3]  = '{1'b0, 3'd1, 32'h0000_0002, 32'h0, 32'hFFFF8899, 1'b0, 1, 1, 12'd0,    12'd0};
        vecs[4]  = '{1'b0, 3'd2, 32'h0000_0002, 32'h0, 32'h33448899, 1'b0, 2, 2, 12'd0,    12'd1};
        vecs[5]  = '{1'b0, 3'd2, 32'h0000_3FFE, 32'h0, 32'hAABBDEAD, 1'b0, 2, 2, 12'd4095, 12'd0};
        vecs[6]  = '{1'b0, 3'd5, 32'h0000_0005, 32'h0, 32'h00002233, 1'b0, 1, 1, 12'd1,    12'd0};
        vecs[7]  = '{1'b0, 3'd1, 32'h0000_0003, 32'h0, 32'h00004488, 1'b0, 2, 2, 12'd0,    12'd1};
        vecs[8]  = '{1'b0, 3'd1, 32'h0000_0001, 32'h0, 32'hFFFF99AA, 1'b0, 1, 1, 12'd0,    12'd0};
        vecs[9]  = '{1'b0, 3'd0, 32'h0000_3FFF, 32'h0, 32'hFFFFFFDE, 1'b0, 1, 1, 12'd4095, 12'd0};
        vecs[10] = '{1'b0, 3'd3, 32'h0000_0000, 32'h0, 32'h00000000, 1'b1, 0, 0, 12'd0,    12'd0};
        vecs[11] = '{1'b0, 3'd7, 32'h0000_0004, 32'h0, 32'h00000000, 1'b1, 0, 0, 12'd0,    12'd0};
        vecs[12] = '{1'b0, 3'd2, 32'h0001_0004, 32'h0, 32'h11223344, 1'b0, 1, 1, 12'd1,    12'd0};

        RST        = 1'b1;
        REQ_VALID  = 1'b0;
        REQ_WE     = 1'b0;
        REQ_FUNCT3 = 3'd0;
        REQ_ADDR   = 32'h0;
        REQ_WDATA  = 32'h0;
        preload_req = 1'b1;

        repeat (3) @(posedge CLK);
        #1;
        chk("rst_req_ready", 32'(REQ_READY), 32'd0);
        chk("rst_rsp_valid", 32'(RSP_VALID), 32'd0);
        chk("rst_rsp_rdata", RSP_RDATA, 32'h0);
        chk("rst_rsp_err",   32'(RSP_ERR), 32'd0);
        chk("rst_mem_csn",   32'(MEM_CSN), 32'd1);
        chk("rst_mem_wen",   32'(MEM_WEN), 32'd1);
        chk("rst_mem_be",    32'(MEM_BE), 32'd0);
        chk("rst_mem_addr",  32'(MEM_ADDR), 32'd0);
        chk("rst_mem_di",    MEM_DI, 32'h0);

        @(negedge CLK);
        RST = 1'b0;
        preload_req = 1'b0;
        #1;
        chk("idle_req_ready", 32'(REQ_READY), 32'd1);
        @(negedge CLK);
        preload();

        for (int i = 0; i < NV; i++) begin
            base = rsp_cnt;
            send(vecs[i].we, vecs[i].f3, vecs[i].addr, vecs[i].wdata, vecs[i].rdata, vecs[i].err);
            REQ_VALID = 1'b0;
            wait_rsp(base + 1);
            chk($sformatf("v%0d_nacc", i), 32'(acc_q.size()), 32'(vecs[i].nacc));
            if (vecs[i].nacc > 0 && acc_q.size() > 0)
                chk($sformatf("v%0d_addr0", i), 32'(acc_q[0].addr), 32'(vecs[i].a0));
            if (vecs[i].nacc > 1 && acc_q.size() > 1)
                chk($sformatf("v%0d_addr1", i), 32'(acc_q[1].addr), 32'(vecs[i].a1));
            if (rsp_cyc_q.size() > 0)
                chk($sformatf("v%0d_latency", i), 32'(rsp_cyc_q[$] - acc_cyc), 32'(vecs[i].lat));
        end

        // Split halfword store across word 0/1
        base = rsp_cnt;
        send(1'b1, 3'd1, 32'h3, 32'h0000CAFE, 32'h0, 1'b0);
        REQ_VALID = 1'b0;
        wait_rsp(base + 1);
        chk("sh_nacc", 32'(acc_q.size()), 32'd2);
        if (acc_q.size() > 1) begin
            chk("sh_acc0_we",   32'(acc_q[0].we), 32'd1);
            chk("sh_acc0_be",   32'(acc_q[0].be), 32'b1000);
            chk("sh_acc0_di",   32'(acc_q[0].di[31:24]), 32'hFE);
            chk("sh_acc1_addr", 32'(acc_q[1].addr), 32'd1);
            chk("sh_acc1_be",   32'(acc_q[1].be), 32'b0001);
            chk("sh_acc1_di",   32'(acc_q[1].di[7:0]), 32'hCA);
        end
        chk("sh_word0", mem[0], 32'hFE99AABB);
        chk("sh_word1", mem[1], 32'h112233CA);

        // Illegal store: error response and no SRAM cycle
        base = rsp_cnt;
        send(1'b1, 3'd3, 32'h4, 32'hFFFFFFFF, 32'h0, 1'b1);
        REQ_VALID = 1'b0;
        wait_rsp(base + 1);
        chk("ill_nacc",  32'(acc_q.size()), 32'd0);
        chk("ill_word0", mem[0], 32'hFE99AABB);
        chk("ill_word1", mem[1], 32'h112233CA);

        // Back-to-back loads: second accepted in RESP of the first
        base = rsp_cnt;
        send(1'b0, 3'd2, 32'h0, 32'h0, 32'hFE99AABB, 1'b0);
        send(1'b0, 3'd2, 32'h4, 32'h0, 32'h112233CA, 1'b0);
        REQ_VALID = 1'b0;
        wait_rsp(base + 2);
        if (rsp_cyc_q.size() > 1)
            chk("b2b_gap", 32'(rsp_cyc_q[$] - rsp_cyc_q[$-1]), 32'd2);

        // Reset arriving in ACC1 of a split word store
        repeat (2) @(negedge CLK);
        preload();
        base = rsp_cnt;
        send(1'b1, 3'd2, 32'h1, 32'hCAFEBABE, 32'h0, 1'b0);
        REQ_VALID = 1'b0;
        @(posedge CLK);
        #1;
        RST = 1'b1;
        #1;
        chk("rstacc1_csn",   32'(MEM_CSN), 32'd1);
        chk("rstacc1_ready", 32'(REQ_READY), 32'd0);
        @(negedge CLK);
        @(posedge CLK);
        #1;
        chk("rst_hold_csn",   32'(MEM_CSN), 32'd1);
        chk("rst_hold_ready", 32'(REQ_READY), 32'd0);
        @(negedge CLK);
        RST = 1'b0;
        #1;
        chk("post_rst_ready", 32'(REQ_READY), 32'd1);
        repeat (4) @(negedge CLK);
        chk("rst_no_rsp", 32'(rsp_cnt - base), 32'd0);
        chk("rst_nacc",   32'(acc_q.size()), 32'd1);
        chk("rst_word0",  mem[0], 32'hFEBABEBB);
        chk("rst_word1",  mem[1], 32'h11223344);
        exp_q.delete();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

// File: doc/dmem_access_unit.md
Name: dmem_access_unit

Overview:
- Load/store front-end that sits directly upstream of the single-port data SRAM in the MEM stage.
- Accepts byte-addressed RV32 load/store requests over a valid/ready handshake.
- Generates the SRAM word address, byte enables and lane-shifted write data, then aligns and sign- or zero-extends read data.
- Accesses that cross a word boundary are split into two back-to-back SRAM accesses under a small FSM.

Parameters:
AWIDTH, 12, SRAM word-address width
SIZE, 4096, SRAM depth in words (2**AWIDTH)

Ports:
CLK  in  1  clock
RST  in  1  reset, synchronous, active-high
REQ_VALID  in  1  request present
REQ_READY  out  1  unit can accept request
REQ_WE  in  1  1=store, 0=load
REQ_FUNCT3  in  3  RV32 size/sign (LB0 LH1 LW2 LBU4 LHU5; SB0 SH1 SW2)
REQ_ADDR  in  32  byte address
REQ_WDATA  in  32  store data, right-justified
RSP_VALID  out  1  one-cycle response strobe
RSP_RDATA  out  32  extended load data (0 for stores/errors)
RSP_ERR  out  1  illegal funct3
MEM_CSN  out  1  SRAM chip select, active-low
MEM_WEN  out  1  SRAM write enable, active-low
MEM_BE  out  4  SRAM byte enables
MEM_ADDR  out  AWIDTH  SRAM word address
MEM_DI  out  32  SRAM write data
MEM_DOUT  in  32  SRAM async read data

Behaviour:
- Reset values: REQ_READY=0 while RST=1; state IDLE; RSP_VALID=0; RSP_RDATA=0; RSP_ERR=0; MEM_CSN=1; MEM_WEN=1; MEM_BE=0; MEM_ADDR=0; MEM_DI=0.
- States: IDLE, ACC0, ACC1, RESP.
- REQ_READY=1 in IDLE and in RESP. The request is accepted on the posedge where REQ_VALID&REQ_READY; address, funct3, WE and WDATA are registered.
- Word address = REQ_ADDR[AWIDTH+1:2]. Byte offset off = REQ_ADDR[1:0]. Address bits above AWIDTH+1 are ignored.
- Split condition: (size=2 and off!=0) or (size=1 and off=3).
- On acceptance:
  - Illegal funct3 (load 3/6/7, store 3-7): go to RESP with RSP_ERR=1. No SRAM cycle.
  - Otherwise go to ACC0.
- ACC0:
  - MEM_CSN=0, MEM_WEN=~WE, MEM_ADDR=word address.
  - Store: MEM_BE = size mask << off, truncated to 4 bits; MEM_DI = WDATA << 8*off.
  - Load: BE is don't-care, driven 0.
  - The SRAM writes on negedge; load data is captured from MEM_DOUT at the ending posedge.
  - Next state is ACC1 if split, else RESP.
- ACC1:
  - MEM_ADDR = word address + 1, wrapping modulo SIZE.
  - Store: MEM_BE = remaining low-lane mask; MEM_DI = WDATA >> 8*(4-off).
  - Next state is RESP.
- Load data: merged = ({second,first} >> 8*off)[31:0]. Single-word loads use first only. Then extract byte/half/word and sign-extend (LB/LH) or zero-extend (LBU/LHU).
- RESP: RSP_VALID=1 for exactly one cycle; RSP_RDATA and RSP_ERR are valid here.
  - If a new request is accepted in RESP, go straight to ACC0 (or RESP again if illegal).
  - Otherwise go to IDLE.
- Latency:
  - Aligned access: RSP_VALID high in the 2nd cycle after the accept edge, i.e. one cycle after the access cycle.
  - Split access: one cycle later than aligned.
  - Back-to-back throughput: one aligned access per 2 cycles.
- MEM_CSN=1 in IDLE and RESP.
- RST in any state: the next posedge forces the reset values and IDLE.
  - A write already committed in ACC0 (negedge) stays.
  - An ACC1 write is committed only if its negedge preceded the RST edge.
  - No RSP_VALID is issued for the aborted request.

Decomposition:
- Shared package dmem_pkg:
  - funct3 encodings (F3_B, F3_H, F3_W, F3_BU, F3_HU)
  - state encoding
  - size-mask function
- Sub-module dmem_align: purely combinational.
  - Store path: BE/DI lane generation for ACC0 and ACC1.
  - Load path: merge/extract/extend.
  - The parent holds the FSM and registers.

Test Plan:
Preload word0=0x8899AABB, word1=0x11223344, word(SIZE-1)=0xDEADBEEF for all scenarios.
- LW addr 0x0 -> one MEM_CSN-low cycle at MEM_ADDR 0; RSP_VALID one cycle later; RSP_RDATA=0x8899AABB, RSP_ERR=0.
- LB addr 0x3 -> RSP_RDATA=0xFFFFFF88. LBU addr 0x3 -> 0x00000088. LH addr 0x2 -> 0xFFFF8899.
- LW addr 0x2 -> two CSN-low cycles at MEM_ADDR 0 then 1; RSP_RDATA=0x33448899. LW addr 4*(SIZE-1)+2 -> second access at MEM_ADDR 0; RSP_RDATA=0xAABBDEAD.
- SH addr 0x3 WDATA 0x0000CAFE -> ACC0: BE=1000, DI[31:24]=0xFE; ACC1: BE=0001, DI[7:0]=0xCA. Readback word0=0xFE99AABB, word1=0x112233CA; RSP_RDATA=0.
- Store funct3=3 -> no CSN-low cycle; RSP_VALID with RSP_ERR=1; memory unchanged. Back-to-back LW accepted in RESP -> RSP_VALID pulses with one cycle gap.
- SW addr 0x1 with RST asserted during ACC1 (before its negedge) -> word0 bytes[3:1] updated, word1 unchanged; no RSP_VALID; MEM_CSN=1 and REQ_READY=0 while RST=1; REQ_READY=1 in IDLE after release.
